// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception unit at the M stage: owns SR/Cause/EPC, decides when to
// take an interrupt or exception, and handles mtc0/mfc0/eret for those registers.
module cp0_exc_unit #(
  parameter logic [31:0] ERROR_ENTRY = 32'h0000_4180,
  parameter logic [4:0]  SR_ADDR     = 5'd12,
  parameter logic [4:0]  CAUSE_ADDR  = 5'd13,
  parameter logic [4:0]  EPC_ADDR    = 5'd14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EN,
  input  logic        EXLClr,
  output logic        req,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic [31:0] EntryPC
);

  logic [5:0]  im_reg;
  logic        exl_reg;
  logic        ie_reg;
  logic        bd_reg;
  logic [5:0]  ip_reg;
  logic [4:0]  exc_code_reg;
  logic [31:0] epc_reg;

  logic        int_req;
  logic        exc_req;
  logic        sr_write;
  logic        epc_write;
  logic [31:0] pc_minus4;
  logic [31:0] sr_value;
  logic [31:0] cause_value;

  assign int_req   = (|(HWInt & im_reg)) & ie_reg & ~exl_reg;
  assign exc_req   = (ExcCodeIn != 5'd0) & ~exl_reg;
  assign req       = int_req | exc_req;
  assign pc_minus4 = PC - 32'd4;

  // A squashed M instruction (req=1) must not commit its mtc0/eret.
  assign sr_write  = EN & ~req & (A2 == SR_ADDR);
  assign epc_write = EN & ~req & (A2 == EPC_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      im_reg       <= 6'd0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= 6'd0;
      exc_code_reg <= 5'd0;
      epc_reg      <= 32'd0;
    end else begin
      ip_reg <= HWInt;
      if (req) begin
        exc_code_reg <= int_req ? 5'd0 : ExcCodeIn;
        bd_reg       <= BDIn;
        epc_reg      <= BDIn ? {pc_minus4[31:2], 2'b00} : {PC[31:2], 2'b00};
        exl_reg      <= 1'b1;
      end else begin
        if (sr_write) begin
          im_reg <= DIn[15:10];
          ie_reg <= DIn[0];
        end
        // eret's clear of EXL beats a simultaneous SR write.
        if (EXLClr) begin
          exl_reg <= 1'b0;
        end else if (sr_write) begin
          exl_reg <= DIn[1];
        end
        if (epc_write) begin
          epc_reg <= {DIn[31:2], 2'b00};
        end
      end
    end
  end

  assign sr_value    = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
  assign cause_value = {bd_reg, 15'd0, ip_reg, 3'd0, exc_code_reg, 2'b00};

  always_comb begin
    DOut = 32'd0;
    if (A1 == SR_ADDR) begin
      DOut = sr_value;
    end else if (A1 == CAUSE_ADDR) begin
      DOut = cause_value;
    end else if (A1 == EPC_ADDR) begin
      DOut = epc_reg;
    end
  end

  assign EPCOut  = epc_reg;
  assign EntryPC = ERROR_ENTRY;

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 block at the M stage of the 5-stage MIPS pipeline.
- Receives exception bookkeeping carried down the pipeline (M_PC, M_ExcCode, M_BD, M_mtc0, M_eret) plus 6 external hardware interrupt lines.
- Owns SR/Cause/EPC and raises req, which flushes all pipeline registers and redirects fetch to the handler entry.
- Receiving end of the exception fields the pipeline registers transport.

Parameters:
- ERROR_ENTRY, 32'h0000_4180, handler address driven on fetch redirect (exported on EntryPC).
- SR_ADDR, 5'd12, CP0 register number of SR.
- CAUSE_ADDR, 5'd13, CP0 register number of Cause.
- EPC_ADDR, 5'd14, CP0 register number of EPC.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- A1  in  5  mfc0 read register number (M_rd).
- A2  in  5  mtc0 write register number (M_rd).
- DIn  in  32  mtc0 write data (forwarded M_RD2).
- PC  in  32  PC of the instruction currently in M (M_PC).
- BDIn  in  1  M instruction sits in a delay slot (M_BD).
- ExcCodeIn  in  5  exception code from the M instruction; 0 = none (M_ExcCode).
- HWInt  in  6  external interrupt lines, level-sensitive.
- EN  in  1  mtc0 write enable (M_mtc0).
- EXLClr  in  1  eret in M (M_eret).
- req  out  1  take exception/interrupt now (combinational).
- DOut  out  32  mfc0 read data (combinational).
- EPCOut  out  32  current EPC, eret target.
- EntryPC  out  32  constant ERROR_ENTRY.

Behaviour:
- Fields: SR.IM=[15:10], SR.EXL=[1], SR.IE=[0], all other SR bits read 0. Cause.BD=[31], Cause.IP=[15:10], Cause.ExcCode=[6:2], all other bits 0. EPC is 32 bits.
- Reset: on posedge clk with reset=1, SR, Cause and EPC clear to 0. Therefore req=0 and DOut=0 for any A1, EPCOut=0. Reset overrides all other inputs in the same cycle.
- IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
- req = IntReq | ExcReq, combinational, same cycle. Interrupt wins over exception when both are present.
- On posedge with req=1:
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? ((PC-4) & ~3) : (PC & ~3).
  - SR.EXL <= 1.
  - mtc0 and eret presented in the same cycle are suppressed, because the M instruction is squashed.
- Cause.IP <= HWInt every non-reset cycle, regardless of req or EXL.
- mtc0 (EN=1, req=0):
  - A2=SR_ADDR writes only IM/EXL/IE from DIn.
  - A2=EPC_ADDR writes DIn & ~3.
  - A2=CAUSE_ADDR and all other numbers are ignored (Cause is read-only).
  - Writes take effect at the clock edge. Readback of the written value starts the next cycle; there is no write-to-read bypass.
- eret (EXLClr=1, req=0): SR.EXL <= 0 at the edge. If EN also writes SR in the same cycle, the eret clear of EXL wins; IM/IE take DIn.
- DOut = register selected by A1 (12/13/14). Any other A1 reads 32'h0.
- EPCOut = EPC register (registered value, not DIn).
- Nesting: while SR.EXL=1, neither interrupts nor exceptions raise req. Cause.IP still tracks HWInt.
- PC values come from the pipeline. Under a flush the pipeline presents ExcCodeIn=0, BD=0 bubbles, so no spurious req follows a taken exception.

Test Plan:
- Reset, then SR write 32'h0000_0401 (IM[10]=1, IE=1) via EN/A2=12; next cycle HWInt=6'b000001, PC=32'h3010 -> req=1 same cycle; after edge Cause=32'h0000_0400 (ExcCode 0), EPC=32'h3010, SR.EXL=1, req drops to 0.
- ExcCodeIn=5'd10 (RI), BDIn=1, PC=32'h3024, EXL=0 -> req=1; after edge EPC=32'h3020, Cause=32'h8000_0028, DOut(A1=13)=32'h8000_0028.
- Interrupt and exception together: IM/IE enabled, HWInt[2]=1, ExcCodeIn=5'd4 -> ExcCode recorded 0 and EPC=PC.
- With EXL=1: ExcCodeIn=5'd12 and enabled HWInt -> req=0, EPC unchanged, Cause.IP follows HWInt. Then EXLClr=1 -> EXL=0 next cycle and the pending interrupt raises req.
- mtc0 A2=14 DIn=32'h0000_3007 -> EPCOut=32'h3004 next cycle. mtc0 A2=13 -> Cause unchanged. Same-cycle req with EN=1 A2=14 -> EPC gets the exception PC, not DIn.
- Mid-operation reset: with EXL=1 and EPC≠0, assert reset -> SR/Cause/EPC=0 next edge, even with HWInt and ExcCodeIn active during that cycle.
